// File: rtl/pc_fetch_unit_pkg.sv
// Shared widths, state encodings and helpers for the PC/fetch stage.
// Optional perf counters are enabled with FETCH_PERF_CNT_EN.
package pc_fetch_unit_pkg;

    localparam int PC_BUS   = 16;
    localparam int INST_BUS = 16;

    localparam logic [PC_BUS-1:0] RESET_PC_DEFAULT = 16'h0000;

    localparam int PERF_CNT_WIDTH = 32;
    localparam int PERF_CNT_NUM   = 2;

    typedef enum logic [1:0] {
        FETCH_ST_IDLE  = 2'd0,
        FETCH_ST_REQ   = 2'd1,
        FETCH_ST_FLUSH = 2'd2
    } fetch_state_t;

    // Saturating increment: the counter sticks at all-ones.
    function automatic logic [PERF_CNT_WIDTH-1:0] sat_inc(
        input logic [PERF_CNT_WIDTH-1:0] value
    );
        return (&value) ? value : value + 1'b1;
    endfunction

endpackage

// File: rtl/pc_fetch_unit_fetch_perf_cnt.sv
// Two saturating event counters: accepted fetch words and squashed ack words.
// Instantiated by pc_fetch_unit only when FETCH_PERF_CNT_EN is defined.
module fetch_perf_cnt
    import pc_fetch_unit_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      fetch_inc,
    input  logic                      squash_inc,
    output logic [PERF_CNT_WIDTH-1:0] fetch_cnt,
    output logic [PERF_CNT_WIDTH-1:0] squash_cnt
);

    logic [PERF_CNT_NUM-1:0]                     inc;
    logic [PERF_CNT_NUM-1:0][PERF_CNT_WIDTH-1:0] cnt_vec;

    assign inc = {squash_inc, fetch_inc};

    for (genvar gi = 0; gi < PERF_CNT_NUM; gi++) begin : g_cnt
        logic [PERF_CNT_WIDTH-1:0] cnt_reg;

        always_ff @(posedge clk) begin
            if (rst) begin
                cnt_reg <= '0;
            end else if (inc[gi]) begin
                cnt_reg <= sat_inc(cnt_reg);
            end
        end

        assign cnt_vec[gi] = cnt_reg;
    end

    assign fetch_cnt  = cnt_vec[0];
    assign squash_cnt = cnt_vec[1];

endmodule

// File: rtl/pc_fetch_unit.sv
// Program counter and instruction-fetch stage with a 1-entry decode buffer.
// Define FETCH_PERF_CNT_EN to add the fetch_cnt / squash_cnt outputs.
module pc_fetch_unit
    import pc_fetch_unit_pkg::*;
#(
    parameter int                   PC_WIDTH   = PC_BUS,
    parameter int                   INST_WIDTH = INST_BUS,
    parameter logic [PC_WIDTH-1:0]  RESET_PC   = RESET_PC_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  jump_en,
    input  logic [PC_WIDTH-1:0]   jump_addr,
    input  logic                  stall,
    output logic                  mem_req,
    output logic [PC_WIDTH-1:0]   mem_addr,
    input  logic                  mem_ack,
    input  logic [INST_WIDTH-1:0] mem_rdata,
    output logic [INST_WIDTH-1:0] inst,
    output logic [PC_WIDTH-1:0]   inst_pc,
    output logic [PC_WIDTH-1:0]   inst_pc_plus1,
    output logic                  inst_valid
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]           fetch_cnt,
    output logic [31:0]           squash_cnt
`endif
);

    fetch_state_t            state_reg, state_next;
    logic [PC_WIDTH-1:0]     pc_reg, pc_next;
    logic [INST_WIDTH-1:0]   inst_reg, inst_next;
    logic [PC_WIDTH-1:0]     inst_pc_reg, inst_pc_next;
    logic                    inst_valid_reg, inst_valid_next;
    logic                    pend_valid_reg, pend_valid_next;
    logic [PC_WIDTH-1:0]     pend_addr_reg, pend_addr_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= FETCH_ST_IDLE;
            pc_reg         <= RESET_PC;
            inst_reg       <= '0;
            inst_pc_reg    <= '0;
            inst_valid_reg <= 1'b0;
            pend_valid_reg <= 1'b0;
            pend_addr_reg  <= '0;
        end else begin
            state_reg      <= state_next;
            pc_reg         <= pc_next;
            inst_reg       <= inst_next;
            inst_pc_reg    <= inst_pc_next;
            inst_valid_reg <= inst_valid_next;
            pend_valid_reg <= pend_valid_next;
            pend_addr_reg  <= pend_addr_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        pc_next         = pc_reg;
        inst_next       = inst_reg;
        inst_pc_next    = inst_pc_reg;
        inst_valid_next = inst_valid_reg;
        pend_valid_next = pend_valid_reg;
        pend_addr_next  = pend_addr_reg;

        case (state_reg)
            FETCH_ST_IDLE: begin
                if (jump_en) begin
                    pc_next = jump_addr;
                end else if (!inst_valid_reg || !stall) begin
                    // Either empty or drained by decode this cycle.
                    inst_valid_next = 1'b0;
                    state_next      = FETCH_ST_REQ;
                end
            end

            FETCH_ST_REQ: begin
                if (mem_ack) begin
                    if (jump_en) begin
                        pc_next = jump_addr;
                    end else begin
                        inst_next       = mem_rdata;
                        inst_pc_next    = pc_reg;
                        inst_valid_next = 1'b1;
                        pc_next         = pc_reg + 1'b1;
                    end
                    state_next = FETCH_ST_IDLE;
                end else if (jump_en) begin
                    // Address must stay stable until the memory answers.
                    pend_addr_next  = jump_addr;
                    pend_valid_next = 1'b1;
                    state_next      = FETCH_ST_FLUSH;
                end
            end

            FETCH_ST_FLUSH: begin
                if (mem_ack) begin
                    if (jump_en) begin
                        pc_next = jump_addr;
                    end else if (pend_valid_reg) begin
                        pc_next = pend_addr_reg;
                    end
                    pend_valid_next = 1'b0;
                    state_next      = FETCH_ST_IDLE;
                end else if (jump_en) begin
                    pend_addr_next = jump_addr;
                end
            end

            default: begin
                state_next = FETCH_ST_IDLE;
            end
        endcase

        // A redirect kills whatever decode is holding, stalled or not.
        if (jump_en) begin
            inst_valid_next = 1'b0;
        end
    end

    assign mem_req       = (state_reg != FETCH_ST_IDLE);
    assign mem_addr      = pc_reg;
    assign inst          = inst_reg;
    assign inst_pc       = inst_pc_reg;
    assign inst_pc_plus1 = inst_pc_reg + 1'b1;
    assign inst_valid    = inst_valid_reg;

`ifdef FETCH_PERF_CNT_EN
    logic fetch_evt;
    logic squash_evt;

    assign fetch_evt  = (state_reg == FETCH_ST_REQ) && mem_ack && !jump_en;
    assign squash_evt = mem_ack && (((state_reg == FETCH_ST_REQ) && jump_en) ||
                                    (state_reg == FETCH_ST_FLUSH));

    fetch_perf_cnt u_perf_cnt (
        .clk        (clk),
        .rst        (rst),
        .fetch_inc  (fetch_evt),
        .squash_inc (squash_evt),
        .fetch_cnt  (fetch_cnt),
        .squash_cnt (squash_cnt)
    );
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Scoreboard bench: decode must see the sequential stream from the latest
// redirect target; memory model acks with random, fixed or zero latency.
`timescale 1ns/1ps
module tb_pc_fetch_unit;

    localparam logic [15:0] RST_PC = 16'h0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        jump_en;
    logic [15:0] jump_addr;
    logic        stall;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack = 1'b0;
    logic [15:0] mem_rdata = 16'h0000;
    logic [15:0] inst;
    logic [15:0] inst_pc;
    logic [15:0] inst_pc_plus1;
    logic        inst_valid;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt;
    logic [31:0] squash_cnt;
`endif

    int total = 0;
    int bad = 0;
    int consumed = 0;
    int mem_mode = 0;   // 0 zero-wait, 1 random, 2 fixed 3-cycle wait, 3 ack always
    int wait_cnt = 0;
    bit mem_a;
    logic [15:0] jump_q[$];

    always #5 clk = ~clk;

    pc_fetch_unit dut (
        .clk           (clk),
        .rst           (rst),
        .jump_en       (jump_en),
        .jump_addr     (jump_addr),
        .stall         (stall),
        .mem_req       (mem_req),
        .mem_addr      (mem_addr),
        .mem_ack       (mem_ack),
        .mem_rdata     (mem_rdata),
        .inst          (inst),
        .inst_pc       (inst_pc),
        .inst_pc_plus1 (inst_pc_plus1),
        .inst_valid    (inst_valid)
`ifdef FETCH_PERF_CNT_EN
        ,
        .fetch_cnt     (fetch_cnt),
        .squash_cnt    (squash_cnt)
`endif
    );

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'h5A3C;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Instruction memory: answers shortly after each rising edge.
    always @(posedge clk) begin
        #1;
        if (mem_req) begin
            case (mem_mode)
                0, 3:    mem_a = 1'b1;
                1:       mem_a = ($urandom_range(0, 2) == 0);
                default: mem_a = (wait_cnt == 3);
            endcase
            if (mem_a) begin
                mem_ack   = 1'b1;
                mem_rdata = mem_word(mem_addr);
                wait_cnt  = 0;
            end else begin
                mem_ack   = 1'b0;
                mem_rdata = 16'($urandom);
                wait_cnt++;
            end
        end else begin
            wait_cnt  = 0;
            mem_ack   = (mem_mode == 3) ? 1'b1 : ($urandom_range(0, 3) == 0);
            mem_rdata = 16'($urandom);
        end
    end

    // Monitor / reference model, sampled on the falling edge.
    logic [15:0] exp_next = RST_PC;
    logic [15:0] exp_plus1;
    logic [15:0] held_addr = 16'h0000;
    bit          outstanding = 1'b0;
    bit          jumped = 1'b0;
    int          exp_fetch = 0;
    int          exp_squash = 0;

    always @(negedge clk) begin
        if (rst) begin
            exp_next    = RST_PC;
            outstanding = 1'b0;
            jumped      = 1'b0;
            exp_fetch   = 0;
            exp_squash  = 0;
            jump_q.delete();
        end else begin
            if (mem_req) begin
                if (outstanding) begin
                    chk("addr_hold", mem_addr, held_addr);
                end else begin
                    chk("req_addr", mem_addr, exp_next);
                    jumped = 1'b0;
                end
                if (mem_ack) begin
                    if (jumped || jump_en) exp_squash++;
                    else exp_fetch++;
                end else if (jump_en) begin
                    jumped = 1'b1;
                end
            end
            if (inst_valid && !stall && !jump_en) begin
                exp_plus1 = exp_next + 16'd1;
                chk("inst_pc", inst_pc, exp_next);
                chk("inst_word", inst, mem_word(exp_next));
                chk("inst_pc_plus1", inst_pc_plus1, exp_plus1);
                $display("consume pc=%h inst=%h", inst_pc, inst);
                consumed++;
                exp_next = exp_plus1;
            end
            if (jump_en && jump_q.size() != 0) begin
                exp_next = jump_q.pop_front();
                $display("redirect to %h", exp_next);
            end
            outstanding = mem_req && !mem_ack;
            held_addr   = mem_addr;
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input bit j, input logic [15:0] a, input bit s);
        jump_en   = j;
        jump_addr = a;
        stall     = s;
        if (j) jump_q.push_back(a);
    endtask

    function automatic logic [15:0] pick_addr();
        case ($urandom_range(0, 3))
            0:       return 16'hFFFE;
            1:       return 16'h0040;
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        rst = 1'b1;
        drive(1'b0, 16'h0000, 1'b0);
        step();
        step();
        chk("rst_mem_req", mem_req, 1'b0);
        chk("rst_inst_valid", inst_valid, 1'b0);
        chk("rst_inst", inst, 16'h0000);
        chk("rst_inst_pc", inst_pc, 16'h0000);
        chk("rst_inst_pc_plus1", inst_pc_plus1, 16'h0001);
        chk("rst_mem_addr", mem_addr, RST_PC);
        rst = 1'b0;

        // Zero-wait streaming from reset
        repeat (20) step();

        // Wrap through FFFF
        drive(1'b1, 16'hFFFE, 1'b0);
        step();
        drive(1'b0, 16'h0000, 1'b0);
        repeat (12) step();

        // Stall with a live buffer: no new request
        for (int i = 0; i < 10 && !inst_valid; i++) step();
        chk("valid_timeout", inst_valid, 1'b1);
        stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("stall_no_req", mem_req, 1'b0);
            chk("stall_valid", inst_valid, 1'b1);
        end
        stall = 1'b0;
        repeat (6) step();

        // Redirect twice while a slow request is outstanding
        mem_mode = 2;
        for (int i = 0; i < 10 && mem_req; i++) step();
        for (int i = 0; i < 10 && !mem_req; i++) step();
        chk("req_timeout", mem_req, 1'b1);
        drive(1'b1, 16'h0100, 1'b0);
        step();
        drive(1'b1, 16'h0200, 1'b0);
        step();
        drive(1'b0, 16'h0000, 1'b0);
        for (int i = 0; i < 3; i++) begin
            chk("flush_no_valid", inst_valid, 1'b0);
            step();
        end
        repeat (12) step();

        // Randomized traffic
        mem_mode = 1;
        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(0, 7) == 0, pick_addr(), $urandom_range(0, 3) == 0);
            step();
        end
        drive(1'b0, 16'h0000, 1'b0);
        repeat (8) step();
`ifdef FETCH_PERF_CNT_EN
        chk("fetch_cnt", fetch_cnt, exp_fetch);
        chk("squash_cnt", squash_cnt, exp_squash);
`endif

        // Reset while a request is outstanding, with acks during reset
        mem_mode = 2;
        for (int i = 0; i < 10 && mem_req; i++) step();
        for (int i = 0; i < 10 && !mem_req; i++) step();
        chk("req_timeout2", mem_req, 1'b1);
        rst = 1'b1;
        mem_mode = 3;
        for (int i = 0; i < 2; i++) begin
            step();
            chk("midrst_mem_req", mem_req, 1'b0);
            chk("midrst_inst_valid", inst_valid, 1'b0);
            chk("midrst_mem_addr", mem_addr, RST_PC);
        end
        rst = 1'b0;
        mem_mode = 0;
        step();
        chk("postrst_inst_valid", inst_valid, 1'b0);
        repeat (12) step();
`ifdef FETCH_PERF_CNT_EN
        chk("fetch_cnt_end", fetch_cnt, exp_fetch);
        chk("squash_cnt_end", squash_cnt, exp_squash);
`endif

        chk("progress", consumed >= 100, 1'b1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
